// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a valid/ready command stream into
// APB SETUP/ACCESS transfers and returns each result on a valid/ready response.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int LAST_INT  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TO_EN     = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [DATA_W-1:0] pwdata_nx;
    logic              rsp_valid_nx, rsp_slverr_nx, rsp_timeout_nx;
    logic [DATA_W-1:0] rsp_rdata_nx;

    // Gated by reset so the source never sees a ready while the bridge is held.
    assign cmd_ready = (state == IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        psel_nx        = psel;
        penable_nx     = penable;
        paddr_nx       = paddr;
        pwrite_nx      = pwrite;
        pwdata_nx      = pwdata;
        rsp_valid_nx   = rsp_valid;
        rsp_rdata_nx   = rsp_rdata;
        rsp_slverr_nx  = rsp_slverr;
        rsp_timeout_nx = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_nx   = cmd_addr;
                    pwrite_nx  = cmd_write;
                    pwdata_nx  = cmd_wdata;
                    psel_nx    = 1'b1;
                    penable_nx = 1'b0;
                    state_nx   = SETUP;
                end
            end
            SETUP: begin
                penable_nx = 1'b1;
                cnt_nx     = '0;
                state_nx   = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over the timeout in the threshold cycle.
                if (pready) begin
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_rdata_nx   = pwrite ? '0 : prdata;
                    rsp_slverr_nx  = pslverr;
                    rsp_timeout_nx = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    state_nx       = RESP;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_rdata_nx   = '0;
                    rsp_slverr_nx  = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    state_nx       = RESP;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            psel        <= psel_nx;
            penable     <= penable_nx;
            paddr       <= paddr_nx;
            pwrite      <= pwrite_nx;
            pwdata      <= pwdata_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_slverr  <= rsp_slverr_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed table-driven bench for apb_master_bridge with an inline APB slave.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int applied = 0;
    int miscompares = 0;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;      // wait states before pready; 99 = never
        logic [31:0] prdata;
        logic        pslverr;
        int          hold;       // cycles rsp_ready stays low in RESP
        int          exp_access;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        int n_access;
        bit done;
        logic [31:0] hold_rdata;
        logic hold_slverr, hold_timeout;
        n_access = 0;
        done = 1'b0;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_write = v.write;
        cmd_wdata = v.wdata;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        check("setup_psel", {30'd0, psel, penable}, 32'd2);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
        if (v.write) check("setup_pwdata", pwdata, v.wdata);
        check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            idle_slave();
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            n_access++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== v.addr)
                check("access_stable", {paddr[29:0], psel, penable}, {v.addr[29:0], 2'b11});
            if (n_access == v.waits + 1) begin
                pready  = 1'b1;
                prdata  = v.prdata;
                pslverr = v.pslverr;
            end else begin
                prdata  = 32'hDEAD_BEEF;
                pslverr = 1'b1;
            end
        end
        check("rsp_valid_seen", {31'd0, done}, 32'd1);
        check("access_cycles", n_access, v.exp_access);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_slverr", {31'd0, rsp_slverr}, {31'd0, v.exp_slverr});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_timeout});
        check("resp_psel", {30'd0, psel, penable}, 32'd0);
        hold_rdata = rsp_rdata;
        hold_slverr = rsp_slverr;
        hold_timeout = rsp_timeout;
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_addr  = 32'h0000_0F00;
            @(negedge pclk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold_rsp", {rsp_rdata[29:0], rsp_slverr, rsp_timeout},
                  {hold_rdata[29:0], hold_slverr, hold_timeout});
            check("hold_no_accept", {31'd0, psel}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_hs_psel", {31'd0, psel}, 32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        //          addr          wr    wdata         waits prdata        err hold acc rdata         serr to
        vecs[0] = '{32'h0000_000C, 1'b1, 32'h0000_00A5, 0,  32'h0000_1234, 1'b0, 0, 1,  32'h0,          1'b0, 1'b0};
        vecs[1] = '{32'h0000_0004, 1'b0, 32'h0,          3,  32'h0000_0060, 1'b0, 0, 4,  32'h0000_0060, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0008, 1'b0, 32'h0,          1,  32'h0000_0077, 1'b1, 0, 2,  32'h0000_0077, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0010, 1'b0, 32'h0,          99, 32'h0,          1'b0, 0, 16, 32'h0,          1'b1, 1'b1};
        vecs[4] = '{32'h0000_0014, 1'b0, 32'h0,          15, 32'h0000_CAFE, 1'b0, 0, 16, 32'h0000_CAFE, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0018, 1'b1, 32'h0000_5A5A, 2,  32'h1111_1111, 1'b0, 5, 3,  32'h0,          1'b0, 1'b0};
        vecs[6] = '{32'h0000_001C, 1'b0, 32'h0,          0,  32'hFFFF_FFFF, 1'b0, 2, 1,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0020, 1'b1, 32'h0000_0003, 0,  32'h2222_2222, 1'b1, 0, 1,  32'h0,          1'b1, 1'b0};

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        idle_slave();
        repeat (3) @(negedge pclk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_ctrl", {27'd0, psel, penable, pwrite, rsp_valid, rsp_slverr}, 32'd0);
        check("rst_data", paddr | pwdata | rsp_rdata | {31'd0, rsp_timeout}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while in ACCESS with pready low
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0024;
        cmd_write = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        check("mid_access_psel", {30'd0, psel, penable}, 32'd3);
        preset = 1'b1;
        @(negedge pclk);
        check("rst_access_psel", {30'd0, psel, penable}, 32'd0);
        check("rst_access_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_access_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rel_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while a response is pending
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0028;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        pready = 1'b1;
        prdata = 32'h0000_0099;
        @(negedge pclk);
        idle_slave();
        check("pend_valid", {31'd0, rsp_valid}, 32'd1);
        check("pend_rdata", rsp_rdata, 32'h0000_0099);
        preset = 1'b1;
        @(negedge pclk);
        check("pend_discard", {31'd0, rsp_valid}, 32'd0);
        check("pend_rdata_clr", rsp_rdata, 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        check("pend_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("pend_rel_valid", {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB initiator converting a simple valid/ready command stream into APB SETUP/ACCESS transfers and returning each result on a valid/ready response channel. It sits between a register-access source (test sequencer or CPU-side logic) and the UART's APB slave port. It drives exactly the APB signal set the UART exposes (address, select, enable, write, write/read data, ready, error) and adds a bounded wait on `pready`.

## Interface
- `ADDR_W`, default 32, paddr/cmd_addr width
- `DATA_W`, default 32, pwdata/prdata width
- `TIMEOUT`, default 16, max ACCESS cycles waiting for `pready`; 0 disables the timeout (wait forever)

Ports:
- `pclk`, in, 1, sole clock, all logic on rising edge
- `preset`, in, 1, synchronous active-high reset
- `cmd_valid`, in, 1, command offered
- `cmd_ready`, out, 1, bridge accepts a command; high only in IDLE
- `cmd_addr`, in, ADDR_W, target address
- `cmd_write`, in, 1, 1 = write, 0 = read
- `cmd_wdata`, in, DATA_W, write data
- `rsp_valid`, out, 1, response available
- `rsp_ready`, in, 1, consumer takes response
- `rsp_rdata`, out, DATA_W, read data; 0 for writes and for timeouts
- `rsp_slverr`, out, 1, `pslverr` sampled at completion, or 1 on timeout
- `rsp_timeout`, out, 1, transfer aborted by timeout
- `paddr`, out, ADDR_W, APB address
- `psel`, out, 1, APB select
- `penable`, out, 1, APB enable
- `pwrite`, out, 1, APB direction
- `pwdata`, out, DATA_W, APB write data
- `prdata`, in, DATA_W, APB read data
- `pready`, in, 1, APB ready
- `pslverr`, in, 1, APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, register `paddr`/`pwrite`/`pwdata` from `cmd_*`, set `psel`=1, and go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0.
  - Unconditionally set `penable`=1, clear the wait counter, and go to ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - If `pready`=1:
    - clear `psel`/`penable`;
    - `rsp_rdata` = `pwrite` ? 0 : `prdata`;
    - `rsp_slverr` = `pslverr`, `rsp_timeout`=0;
    - set `rsp_valid`=1 and go to RESP.
  - Else if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1:
    - clear `psel`/`penable`;
    - `rsp_rdata`=0, `rsp_slverr`=1, `rsp_timeout`=1;
    - set `rsp_valid`=1 and go to RESP.
  - Else increment the counter.
  - Counter width is $clog2(TIMEOUT+1), minimum 1. The counter saturates, never wraps.
- **RESP**
  - `rsp_*` are held stable while `rsp_valid`=1.
  - On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- `paddr`/`pwrite`/`pwdata` are stable from SETUP through the end of ACCESS. They keep their values until the next accept.
- `pslverr`/`prdata` are ignored outside the completing ACCESS cycle.
- One transfer is outstanding at a time. A new command is never accepted in SETUP/ACCESS/RESP.

## Timing
- **Reset values:**
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata` = 0;
  - `rsp_valid`, `rsp_rdata`, `rsp_slverr`, `rsp_timeout` = 0;
  - counter = 0.
- `cmd_ready` is 0 while `preset`=1 and 1 in the first cycle after reset deasserts.
- The accept edge and the SETUP cycle are adjacent. There is exactly one SETUP cycle.
- Zero-wait transfer: accept (T0) → SETUP (T1) → ACCESS with `pready` (T2) → `rsp_valid` high at T3.
- Minimum period is 4 cycles per command with `rsp_ready` tied high.
- `pready` in the same cycle as the timeout threshold: `pready` wins, and the transfer completes normally.
- With `TIMEOUT`=16 and `pready` stuck low, ACCESS lasts 16 cycles. `psel` drops and `rsp_valid` rises on the following edge.
- Reset mid-transfer (any state) has these effects at the next edge:
  - `psel`/`penable` fall;
  - the state goes to IDLE;
  - no response is produced and a pending response is discarded.
- `cmd_valid` held high during RESP is not accepted until the cycle after the `rsp_ready` handshake (IDLE).

## Test plan
- Write 0x0000_000C ← 0xA5: the APB sequence is SETUP then ACCESS. With `pready`=1 in the first ACCESS cycle, `rsp_valid` rises 3 cycles after accept with `rsp_rdata`=0, `rsp_slverr`=0 and `rsp_timeout`=0.
- Read 0x0000_0004, slave returns `prdata`=0x0000_0060 after 3 wait states: ACCESS lasts 4 cycles with paddr/psel/penable stable, and `rsp_rdata`=0x60.
- Read with `pslverr`=1 at completion: `rsp_slverr`=1 and `rsp_timeout`=0.
- `pready` stuck low, `TIMEOUT`=16: ACCESS lasts exactly 16 cycles, then `rsp_timeout`=1, `rsp_slverr`=1, `rsp_rdata`=0. A `pready` pulse on the 16th cycle instead yields normal completion.
- Back-to-back commands with `rsp_ready` held low for 5 cycles: `cmd_ready` stays 0 and the response stays stable. The second command is accepted the cycle after the handshake.
- Assert `preset` during ACCESS: `psel`/`penable`=0 and no `rsp_valid` after the next edge, and `cmd_ready`=1 after reset releases.
